// File: rtl/mult_share_arbiter.sv
// Round-robin scheduler sharing one combinational multiplier among NUM_REQ requesters.
// Optional MULT_ARB_ZERO_SKIP_EN: zero operands bypass the multiplier with a 0 product.
module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 1,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [2*WIDTH-1:0]       mul_p,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_p,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);
    localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

    state_e               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0]   rsp_p_q, rsp_p_d;

    logic                 gnt_any;
    logic [ID_W-1:0]      gnt_idx;
    logic [NUM_REQ-1:0]   gnt_oh;
    logic [WIDTH-1:0]     gnt_a;
    logic [WIDTH-1:0]     gnt_b;
    logic                 zero_skip;

    // Search upward from the slot after the last winner.
    always_comb begin
        int sum;
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        sum     = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            sum = int'(ptr_q) + off;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            if (!gnt_any && req_valid[sum]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(sum);
            end
        end
        if (state_q == IDLE && gnt_any) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

    assign gnt_a = req_a[gnt_idx*WIDTH +: WIDTH];
    assign gnt_b = req_b[gnt_idx*WIDTH +: WIDTH];

`ifdef MULT_ARB_ZERO_SKIP_EN
    assign zero_skip = (gnt_a == '0) || (gnt_b == '0);
`else
    assign zero_skip = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_p_d     = rsp_p_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    ptr_d = gnt_idx;
                    id_d  = gnt_idx;
                    if (zero_skip) begin
                        // Multiplier inputs left untouched to avoid toggling.
                        rsp_p_d     = '0;
                        rsp_id_d    = gnt_idx;
                        rsp_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        mul_a_d = gnt_a;
                        mul_b_d = gnt_b;
                        cnt_d   = CNT_INIT;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_p_d     = mul_p;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= PTR_RST;
            id_q        <= '0;
            cnt_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_p_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_p_q     <= rsp_p_d;
        end
    end

    assign req_ready = gnt_oh;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_p     = rsp_p_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: MUL_LAT=1 instance with scoreboard, MUL_LAT=3 instance.
// Expected products come from a local approximate-multiplier model.
module tb_mult_share_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]   req_valid, req_ready;
    logic [127:0] req_a, req_b;
    logic [31:0]  mul_a, mul_b;
    logic [63:0]  mul_p, rsp_p;
    logic         rsp_valid, rsp_ready, busy;
    logic [1:0]   rsp_id;

    logic [3:0]   v3, rr3;
    logic [127:0] a3, b3;
    logic [31:0]  mul_a3, mul_b3;
    logic [63:0]  mul_p3, rsp_p3;
    logic         rsp_valid3, rdy3, busy3;
    logic [1:0]   rsp_id3;

    function automatic logic [63:0] amul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        return p & ~64'hF;
    endfunction

    assign mul_p  = amul(mul_a, mul_b);
    assign mul_p3 = amul(mul_a3, mul_b3);

    mult_share_arbiter #(.NUM_REQ(4), .WIDTH(32), .MUL_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy)
    );

    mult_share_arbiter #(.NUM_REQ(4), .WIDTH(32), .MUL_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v3), .req_ready(rr3),
        .req_a(a3), .req_b(b3),
        .mul_a(mul_a3), .mul_b(mul_b3), .mul_p(mul_p3),
        .rsp_valid(rsp_valid3), .rsp_ready(rdy3),
        .rsp_id(rsp_id3), .rsp_p(rsp_p3), .busy(busy3)
    );

    typedef struct {
        logic [1:0]  id;
        logic [63:0] p;
    } exp_t;

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    exp_t  sb_q[$];
    int    grant_log[$];
    time   grant_t[$];
    int    n_vec = 0;
    int    n_err = 0;
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;
    exp_t  mon_e;
    int    mon_g;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Scoreboard: push at accept, pop and compare at response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != 4'd0) begin
                mon_g   = oh2idx(req_ready);
                mon_e.id = 2'(mon_g);
                mon_e.p  = amul(req_a[mon_g*32 +: 32], req_b[mon_g*32 +: 32]);
                sb_q.push_back(mon_e);
                grant_log.push_back(mon_g);
                grant_t.push_back($time);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_empty: got response id %0d expected none", rsp_id);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("sb_id", 64'(rsp_id), 64'(mon_e.id));
                    chk("sb_p", rsp_p, mon_e.p);
                end
            end
        end
    end

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (busy && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("idle", 64'(busy), 64'd0);
    endtask

    task automatic run_single(input int idx, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        logic skip;
        logic [3:0] oh;
`ifdef MULT_ARB_ZERO_SKIP_EN
        skip = (a == 0) || (b == 0);
`else
        skip = 1'b0;
`endif
        oh = 4'b0001 << idx;
        @(posedge clk); #1;
        req_a[idx*32 +: 32] = a;
        req_b[idx*32 +: 32] = b;
        req_valid = oh;
        rsp_ready = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (req_ready == 4'd0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("grant", 64'(req_ready), 64'(oh));
        @(posedge clk); #1;
        req_valid = 4'd0;
        req_a[idx*32 +: 32] = $urandom;
        if (skip) begin
            chk("mul_a_kept", 64'(mul_a), 64'(last_a));
            chk("mul_b_kept", 64'(mul_b), 64'(last_b));
        end else begin
            chk("mul_a", 64'(mul_a), 64'(a));
            chk("mul_b", 64'(mul_b), 64'(b));
            last_a = a;
            last_b = b;
        end
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 64'(cyc), skip ? 64'd0 : 64'd1);
        chk("rsp_id", 64'(rsp_id), 64'(idx));
        chk("rsp_p", rsp_p, skip ? 64'd0 : amul(a, b));
        @(posedge clk); #1;
        chk("busy_drop", 64'(busy), 64'd0);
        chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        vec_t tbl[6];
        exp_t pend;
        int   cyc;

        tbl[0] = '{0, 32'd65600, 32'd150};
        tbl[1] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[2] = '{2, 32'd12345, 32'd678};
        tbl[3] = '{3, 32'd1, 32'd1};
        tbl[4] = '{0, 32'h8000_0000, 32'd2};
        tbl[5] = '{2, 32'd0, 32'd12345};

        rst_n = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        v3 = '0; a3 = '0; b3 = '0; rdy3 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mul_a", 64'(mul_a), 64'd0);
        chk("rst_mul_b", 64'(mul_b), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_p", rsp_p, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_busy3", 64'(busy3), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_single(tbl[i].idx, tbl[i].a, tbl[i].b);
        end

        // All four requesting; pointer parked at 3 so order starts at 0.
        run_single(3, 32'd7, 32'd9);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = 32'(100 + i);
            req_b[i*32 +: 32] = 32'(1000 * i + 3);
        end
        grant_log.delete();
        grant_t.delete();
        req_valid = 4'hF;
        cyc = 0;
        while (grant_log.size() < 6 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        req_valid = 4'd0;
        chk("rr_count", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) chk("rr_order", 64'(grant_log[i]), 64'(i % 4));
        end
        for (int i = 1; i < 6; i++) begin
            if (i < grant_t.size()) chk("rr_gap", 64'((grant_t[i] - grant_t[i-1]) / 10), 64'd3);
        end
        wait_idle();

        // Backpressure with every requester active.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL bp_pending: got 0 entries expected 1");
            pend = '{2'd0, 64'd0};
        end else begin
            pend = sb_q[0];
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_p", rsp_p, pend.p);
            chk("bp_id", 64'(rsp_id), 64'(pend.id));
            chk("bp_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_no_same_cycle_grant", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("bp_next_grant", 64'(req_ready), 64'(4'b0001 << ((pend.id + 1) % 4)));
        @(posedge clk); #1;
        req_valid = 4'd0;
        wait_idle();

        // MUL_LAT=3 instance: hold operands, ignore late operand changes.
        @(posedge clk); #1;
        a3[32 +: 32] = 32'd4294967294;
        b3[32 +: 32] = 32'd1024;
        v3 = 4'b0010;
        @(negedge clk);
        cyc = 0;
        while (rr3 == 4'd0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("l3_grant", 64'(rr3), 64'h2);
        @(posedge clk); #1;
        v3 = 4'd0;
        a3[32 +: 32] = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            chk("l3_mul_a", 64'(mul_a3), 64'd4294967294);
            chk("l3_mul_b", 64'(mul_b3), 64'd1024);
            chk("l3_early", 64'(rsp_valid3), 64'd0);
            @(posedge clk); #1;
        end
        chk("l3_valid", 64'(rsp_valid3), 64'd1);
        chk("l3_p", rsp_p3, amul(32'd4294967294, 32'd1024));
        chk("l3_id", 64'(rsp_id3), 64'd1);
        @(posedge clk); #1;
        chk("l3_idle", 64'(busy3), 64'd0);

        // Asynchronous reset mid-operation; pointer returns to favour 0.
        run_single(2, 32'd5, 32'd6);
        @(posedge clk); #1;
        req_a[32 +: 32] = 32'd11;
        req_b[32 +: 32] = 32'd13;
        req_valid = 4'b0010;
        @(negedge clk);
        cyc = 0;
        while (req_ready == 4'd0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("ar_grant", 64'(req_ready), 64'h2);
        @(posedge clk); #1;
        req_valid = 4'd0;
        chk("ar_busy_before", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        chk("ar_mul_a", 64'(mul_a), 64'd0);
        chk("ar_mul_b", 64'(mul_b), 64'd0);
        chk("ar_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("ar_rsp_id", 64'(rsp_id), 64'd0);
        chk("ar_rsp_p", rsp_p, 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = 4'hF;
        @(negedge clk);
        chk("ar_first_winner", 64'(req_ready), 64'h1);
        @(posedge clk); #1;
        req_valid = 4'd0;
        wait_idle();
        repeat (2) @(posedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Round-robin scheduler that shares one combinational radix4approx 32x32 approximate multiplier among NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block latches the winning pair and drives it onto the multiplier for MUL_LAT cycles, then captures the 64-bit product.
- It returns the product with the requester ID on a single response channel with valid/ready backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WIDTH, 32, operand width; product width is 2*WIDTH.
- MUL_LAT, 1, settle cycles operands are held on the multiplier before capture (1..15).
- ID_W, $clog2(NUM_REQ), requester ID width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester operand-pair valid.
- req_ready  output  NUM_REQ  one-hot grant/accept.
- req_a  input  NUM_REQ*WIDTH  flattened A operands; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  flattened B operands, same packing as req_a.
- mul_a  output  WIDTH  registered A to the multiplier.
- mul_b  output  WIDTH  registered B to the multiplier.
- mul_p  input  2*WIDTH  product from the multiplier.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_W  index of the requester that owns rsp_p.
- rsp_p  output  2*WIDTH  captured product.
- busy  output  1  high whenever state != IDLE.

Behaviour:
Reset:
- All registered outputs are 0: mul_a, mul_b, rsp_valid, rsp_id, rsp_p, busy.
- State is IDLE.
- RR pointer = NUM_REQ-1, so requester 0 has top priority first.
- Reset is asynchronous and may assert mid-operation; any in-flight operation and any unconsumed response are discarded.

FSM states: IDLE, ISSUE, HOLD.

IDLE:
- req_ready is combinational: a one-hot grant to the first asserted req_valid searching upward from pointer+1 (mod NUM_REQ).
- req_ready is all-zero if no req_valid is asserted.
- On an edge with a grant (accept):
  - latch that requester's A into mul_a and B into mul_b;
  - latch its index into the ID register;
  - pointer <= granted index;
  - load cnt <= MUL_LAT-1;
  - go to ISSUE.

ISSUE:
- req_ready = 0.
- mul_a and mul_b are held stable.
- If cnt != 0: cnt decrements each edge.
- If cnt == 0: at that edge rsp_p <= mul_p, rsp_id <= latched ID, rsp_valid <= 1, go to HOLD.
- Timing: with accept at edge k, rsp_valid is high from edge k+MUL_LAT.

HOLD:
- req_ready = 0.
- rsp_valid, rsp_p and rsp_id are held stable until the edge where rsp_valid && rsp_ready.
- At that edge: rsp_valid <= 0, go to IDLE.
- No grant occurs in the same cycle as the response handshake.
- Throughput is one operation per MUL_LAT+2 cycles minimum.

Rules:
- A requester that drops req_valid before being granted is simply skipped.
- req_a/req_b are sampled only at accept, so later changes do not affect an operation in flight.
- mul_p is sampled only in the final ISSUE cycle.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 other grants.
- Products are unsigned, 2*WIDTH bits, passed through unmodified; the approximation error belongs to the multiplier.

Optional Feature:
MULT_ARB_ZERO_SKIP_EN:
- Defined: at accept, if the granted A == 0 or B == 0, the block bypasses ISSUE.
  - At the accept edge: rsp_p <= 0, rsp_id <= index, rsp_valid <= 1, go straight to HOLD.
  - mul_a and mul_b are not updated (they retain their prior values, saving multiplier toggling).
  - Pointer update is unchanged.
- Undefined: zero operands take the normal ISSUE path and rsp_p = mul_p.

Test Plan:
1. Reset then a single request: req_valid=4'b0001, A=65600, B=150, MUL_LAT=1.
   - req_ready[0] high in the accept cycle.
   - rsp_valid high 1 cycle after accept, rsp_id=0, rsp_p equals the model multiplier output for (65600,150).
   - busy falls after rsp_ready.
2. All four requesting continuously, rsp_ready=1.
   - Grant order 0,1,2,3,0,1.
   - rsp_id follows the same order.
   - 3 cycles between successive accepts at MUL_LAT=1.
3. Backpressure: hold rsp_ready=0 for 5 cycles while req_valid=4'b1111.
   - rsp_valid, rsp_p and rsp_id stay stable.
   - req_ready stays 0.
   - The next grant occurs only after the IDLE cycle following rsp_ready=1.
4. MUL_LAT=3, A=4294967294, B=1024.
   - mul_a and mul_b stable for 3 cycles.
   - rsp_valid at accept+3.
   - Changing req_a after accept does not alter rsp_p.
5. Assert rst_n=0 during ISSUE with rsp pending.
   - All outputs go to 0 immediately (asynchronous).
   - After release, requester 0 wins first regardless of the previous pointer.
6. With MULT_ARB_ZERO_SKIP_EN defined: A=0, B=12345.
   - rsp_valid high at the accept edge with rsp_p=0.
   - mul_a and mul_b unchanged.
   - Without the macro: rsp_valid at accept+MUL_LAT and rsp_p = mul_p.
